// File: rtl/rf_pkg.sv
// Shared constants and helpers for the reg_file_cfg register file.
// Optional build macro used by the top: RF_PARITY_EN (per-entry parity storage).
package rf_pkg;

   localparam logic [7:0] ADDR_REG0 = 8'd0;
   localparam logic [7:0] ADDR_REG1 = 8'd1;
   localparam logic [7:0] ADDR_REG2 = 8'd2;
   localparam logic [7:0] ADDR_REG3 = 8'd3;

   localparam logic [7:0] REG2_RST = 8'b100000_01;
   localparam logic [7:0] REG3_RST = 8'd32;

   localparam logic [5:0] PRESC_8  = 6'd8;
   localparam logic [5:0] PRESC_16 = 6'd16;
   localparam logic [5:0] PRESC_32 = 6'd32;

   // High when the byte has an odd number of ones, i.e. the bit that makes the stored word even parity.
   function automatic logic odd_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/rf_cfg_guard.sv
// Write-legality check for the UART config (REG2) and RX divider ratio (REG3) entries.
module rf_cfg_guard
   import rf_pkg::*;
(
   input  logic [7:0] Address,
   input  logic [7:0] WrData,
   output logic       wr_legal
);

   // Decide whether a write of WrData to Address may be committed.
   always_comb begin
      wr_legal = 1'b1;
      case (Address)
         ADDR_REG2: begin
            if ((WrData[7:2] == PRESC_8) || (WrData[7:2] == PRESC_16) || (WrData[7:2] == PRESC_32)) begin
               wr_legal = 1'b1;
            end else begin
               wr_legal = 1'b0;
            end
         end
         ADDR_REG3: begin
            if (WrData == 8'd0) begin
               wr_legal = 1'b0;
            end else begin
               wr_legal = 1'b1;
            end
         end
         default: wr_legal = 1'b1;
      endcase
   end

endmodule

// File: rtl/reg_file_cfg.sv
// Register file downstream of the system controller; exports REG0..REG3 live.
// Build macro RF_PARITY_EN adds an even-parity bit per entry and drives Par_Err.
module reg_file_cfg
   import rf_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8
)(
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic                  WrEn,
   input  logic                  RdEn,
   input  logic [7:0]            Address,
   input  logic [DATA_WIDTH-1:0] WrData,
   output logic [DATA_WIDTH-1:0] RdData,
   output logic                  RdData_Valid,
   output logic                  Addr_Err,
   output logic                  Cfg_Err,
   output logic                  Par_Err,
   output logic [DATA_WIDTH-1:0] REG0,
   output logic [DATA_WIDTH-1:0] REG1,
   output logic [DATA_WIDTH-1:0] REG2,
   output logic [DATA_WIDTH-1:0] REG3
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [8:0] DEPTH_L = 9'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         w_idx;
   logic                  w_addr_ok;
   logic                  w_wr_legal;
   logic                  w_wr_do;
   logic                  w_rd_acc;
   logic                  w_cfg_rej;

   function automatic logic [DATA_WIDTH-1:0] rst_val(input int idx);
      if (idx == int'(ADDR_REG2)) begin
         return REG2_RST;
      end else if (idx == int'(ADDR_REG3)) begin
         return REG3_RST;
      end else begin
         return '0;
      end
   endfunction

   rf_cfg_guard u_guard (
      .Address  (Address),
      .WrData   (WrData),
      .wr_legal (w_wr_legal)
   );

   assign w_idx     = Address[AW-1:0];
   assign w_addr_ok = ({1'b0, Address} < DEPTH_L);
   // A simultaneous read is dropped: the write always wins the port.
   assign w_rd_acc  = RdEn && !WrEn;
   assign w_wr_do   = WrEn && w_addr_ok && w_wr_legal;
   assign w_cfg_rej = WrEn && w_addr_ok && !w_wr_legal;

   // Storage array, reset to the UART/divider defaults.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= rst_val(i);
         end
      end else if (w_wr_do) begin
         r_mem[w_idx] <= WrData;
      end else begin
         r_mem[w_idx] <= r_mem[w_idx];
      end
   end

   // Read data, valid and error pulses, all landing in the cycle after the request.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         RdData       <= '0;
         RdData_Valid <= 1'b0;
         Addr_Err     <= 1'b0;
         Cfg_Err      <= 1'b0;
      end else begin
         RdData_Valid <= w_rd_acc;
         Addr_Err     <= (WrEn || RdEn) && !w_addr_ok;
         Cfg_Err      <= w_cfg_rej;
         if (w_rd_acc) begin
            RdData <= w_addr_ok ? r_mem[w_idx] : '0;
         end else begin
            RdData <= RdData;
         end
      end
   end

`ifdef RF_PARITY_EN
   logic r_par [DEPTH];

   // Parity bit per entry, captured from WrData on every committed write.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_par[i] <= odd_parity(rst_val(i));
         end
      end else if (w_wr_do) begin
         r_par[w_idx] <= odd_parity(WrData);
      end else begin
         r_par[w_idx] <= r_par[w_idx];
      end
   end

   // Parity recheck on accepted in-range reads; out-of-range reads return 0 and never flag.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         Par_Err <= 1'b0;
      end else begin
         Par_Err <= w_rd_acc && w_addr_ok && (odd_parity(r_mem[w_idx]) != r_par[w_idx]);
      end
   end
`else
   assign Par_Err = 1'b0;
`endif

   assign REG0 = r_mem[0];
   assign REG1 = r_mem[1];
   assign REG2 = r_mem[2];
   assign REG3 = r_mem[3];

endmodule
